// File: rtl/srca_fwd_stage.sv
// srca_fwd_stage: registered ALU operand-A select with rs1 forwarding, load-use stall and valid/ready handshake
module srca_fwd_stage #(
    parameter int XLEN = 32,
    parameter int NFWD = 2,
    parameter int CNTW = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           sel_a,
    input  logic [4:0]           rs1_addr,
    input  logic [XLEN-1:0]      rdata1,
    input  logic [XLEN-1:0]      pc,
    input  logic [NFWD-1:0]      fwd_valid,
    input  logic [NFWD-1:0]      fwd_pending,
    input  logic [5*NFWD-1:0]    fwd_rd,
    input  logic [XLEN*NFWD-1:0] fwd_data,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      src_a,
    output logic                 fwd_hit,
    output logic                 hazard,
    output logic [CNTW-1:0]      stall_cnt
);
    logic            hit;
    logic            win_pend;
    logic [XLEN-1:0] win_data;
    logic            is_rs1;
    logic            nz;
    logic [XLEN-1:0] opnd;
    logic            accept;

    // scan oldest to youngest so the lowest-index match overwrites and wins
    always_comb begin
        hit = 1'b0;
        win_pend = 1'b0;
        win_data = '0;
        for (int i = NFWD - 1; i >= 0; i--)
            if (fwd_valid[i] && fwd_rd[5*i +: 5] == rs1_addr) begin
                hit = 1'b1;
                win_pend = fwd_pending[i];
                win_data = fwd_data[XLEN*i +: XLEN];
            end
    end

    assign is_rs1   = sel_a == 2'd1;
    assign nz       = rs1_addr != 5'd0;
    assign hazard   = in_valid & is_rs1 & nz & hit & win_pend;
    assign opnd     = sel_a == 2'd0 ? pc : !(is_rs1 && nz) ? '0 : hit ? win_data : rdata1;
    assign in_ready = (~out_valid | out_ready) & ~hazard & ~flush;
    assign accept   = in_valid & in_ready;

    // output register: flush kills, accept loads, consumption without refill empties
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            src_a <= '0;
            fwd_hit <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            src_a <= opnd;
            fwd_hit <= is_rs1 & nz & hit;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // saturating count of cycles lost to a pending producer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (hazard && !flush && !(&stall_cnt))
            stall_cnt <= stall_cnt + 1'b1;
    end
endmodule

// File: tb/tb_srca_fwd_stage.sv
// tb_srca_fwd_stage: vector table plus directed sequences for the operand-A stage
module tb_srca_fwd_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready, in_ready_s;
    logic [1:0]  sel_a = '0;
    logic [4:0]  rs1_addr = '0;
    logic [31:0] rdata1 = '0;
    logic [31:0] pc = '0;
    logic [1:0]  fwd_valid = '0;
    logic [1:0]  fwd_pending = '0;
    logic [9:0]  fwd_rd = '0;
    logic [63:0] fwd_data = '0;
    logic        flush = 1'b0;
    logic        out_valid, out_valid_s;
    logic        out_ready = 1'b1;
    logic [31:0] src_a, src_a_s;
    logic        fwd_hit, fwd_hit_s;
    logic        hazard, hazard_s;
    logic [15:0] stall_cnt;
    logic [1:0]  stall_cnt_s;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  sel;
        logic [4:0]  rs1;
        logic [31:0] rd1;
        logic [31:0] pcv;
        logic [1:0]  fv;
        logic [1:0]  fp;
        logic [9:0]  frd;
        logic [63:0] fd;
        logic [31:0] exp_a;
        logic        exp_hit;
        logic        exp_haz;
    } vec_t;
    vec_t vecs[10];

    srca_fwd_stage #(.XLEN(32), .NFWD(2), .CNTW(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .sel_a(sel_a), .rs1_addr(rs1_addr), .rdata1(rdata1), .pc(pc),
        .fwd_valid(fwd_valid), .fwd_pending(fwd_pending), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .src_a(src_a),
        .fwd_hit(fwd_hit), .hazard(hazard), .stall_cnt(stall_cnt)
    );

    srca_fwd_stage #(.XLEN(32), .NFWD(2), .CNTW(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .sel_a(sel_a), .rs1_addr(rs1_addr), .rdata1(rdata1), .pc(pc),
        .fwd_valid(fwd_valid), .fwd_pending(fwd_pending), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .flush(flush), .out_valid(out_valid_s), .out_ready(out_ready), .src_a(src_a_s),
        .fwd_hit(fwd_hit_s), .hazard(hazard_s), .stall_cnt(stall_cnt_s)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_hazard(input logic pend);
        in_valid = 1'b1;
        sel_a = 2'd1;
        rs1_addr = 5'd7;
        rdata1 = 32'h5555;
        fwd_valid = 2'b01;
        fwd_pending = {1'b0, pend};
        fwd_rd = {5'd0, 5'd7};
        fwd_data = {32'h0, 32'h1234};
    endtask

    initial begin
        vecs[0] = '{2'd0, 5'd5, 32'h11, 32'h100, 2'b00, 2'b00, {5'd0, 5'd0}, {32'h0, 32'h0}, 32'h100, 1'b0, 1'b0};
        vecs[1] = '{2'd1, 5'd5, 32'h11, 32'h104, 2'b11, 2'b00, {5'd5, 5'd5}, {32'hBB, 32'hAA}, 32'hAA, 1'b1, 1'b0};
        vecs[2] = '{2'd1, 5'd5, 32'h11, 32'h108, 2'b10, 2'b00, {5'd5, 5'd5}, {32'hBB, 32'hAA}, 32'hBB, 1'b1, 1'b0};
        vecs[3] = '{2'd1, 5'd5, 32'h11, 32'h10C, 2'b00, 2'b00, {5'd5, 5'd5}, {32'hBB, 32'hAA}, 32'h11, 1'b0, 1'b0};
        vecs[4] = '{2'd1, 5'd0, 32'h11, 32'h110, 2'b01, 2'b01, {5'd0, 5'd0}, {32'h0, 32'hFF}, 32'h0, 1'b0, 1'b0};
        vecs[5] = '{2'd2, 5'd5, 32'h11, 32'h114, 2'b11, 2'b00, {5'd5, 5'd5}, {32'hBB, 32'hAA}, 32'h0, 1'b0, 1'b0};
        vecs[6] = '{2'd3, 5'd5, 32'h11, 32'h118, 2'b11, 2'b00, {5'd5, 5'd5}, {32'hBB, 32'hAA}, 32'h0, 1'b0, 1'b0};
        vecs[7] = '{2'd1, 5'd5, 32'h11, 32'h11C, 2'b11, 2'b10, {5'd5, 5'd5}, {32'hBB, 32'hAA}, 32'hAA, 1'b1, 1'b0};
        vecs[8] = '{2'd1, 5'd5, 32'h11, 32'h120, 2'b11, 2'b10, {5'd5, 5'd6}, {32'hBB, 32'hAA}, 32'h0, 1'b0, 1'b1};
        vecs[9] = '{2'd0, 5'd5, 32'h11, 32'h124, 2'b01, 2'b01, {5'd0, 5'd5}, {32'h0, 32'hAA}, 32'h124, 1'b0, 1'b0};

        #12;
        chk("reset out_valid", out_valid, 0);
        chk("reset src_a", src_a, 0);
        chk("reset fwd_hit", fwd_hit, 0);
        chk("reset stall_cnt", stall_cnt, 0);
        rst_n = 1'b1;
        step();

        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            sel_a = vecs[k].sel;
            rs1_addr = vecs[k].rs1;
            rdata1 = vecs[k].rd1;
            pc = vecs[k].pcv;
            fwd_valid = vecs[k].fv;
            fwd_pending = vecs[k].fp;
            fwd_rd = vecs[k].frd;
            fwd_data = vecs[k].fd;
            #1;
            chk($sformatf("vec%0d hazard", k), hazard, vecs[k].exp_haz);
            if (vecs[k].exp_haz) begin
                chk($sformatf("vec%0d in_ready", k), in_ready, 0);
            end else begin
                step();
                chk($sformatf("vec%0d out_valid", k), out_valid, 1);
                chk($sformatf("vec%0d src_a", k), src_a, vecs[k].exp_a);
                chk($sformatf("vec%0d fwd_hit", k), fwd_hit, vecs[k].exp_hit);
            end
        end
        in_valid = 1'b0;
        step();
        chk("idle drains out_valid", out_valid, 0);
        chk("no stall counted yet", stall_cnt, 0);

        load_hazard(1'b1);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("load-use hazard c%0d", c), hazard, 1);
            chk($sformatf("load-use in_ready c%0d", c), in_ready, 0);
            step();
            chk($sformatf("load-use no accept c%0d", c), out_valid, 0);
        end
        chk("load-use stall_cnt", stall_cnt, 3);
        fwd_pending = 2'b00;
        #1;
        chk("load-use hazard clears", hazard, 0);
        chk("load-use in_ready", in_ready, 1);
        step();
        chk("load-use out_valid", out_valid, 1);
        chk("load-use src_a", src_a, 32'h1234);
        chk("load-use fwd_hit", fwd_hit, 1);
        chk("load-use stall_cnt held", stall_cnt, 3);

        out_ready = 1'b0;
        load_hazard(1'b1);
        flush = 1'b1;
        #1;
        chk("flush in_ready", in_ready, 0);
        step();
        chk("flush out_valid", out_valid, 0);
        chk("flush stall_cnt unchanged", stall_cnt, 3);
        flush = 1'b0;
        out_ready = 1'b1;

        in_valid = 1'b1;
        sel_a = 2'd0;
        pc = 32'h40;
        fwd_valid = 2'b00;
        fwd_pending = 2'b00;
        step();
        chk("bp accept src_a", src_a, 32'h40);
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            pc = 32'h50 + 32'(c);
            sel_a = 2'(c % 2);
            rs1_addr = 5'd3;
            rdata1 = 32'h99;
            #1;
            chk($sformatf("bp in_ready c%0d", c), in_ready, 0);
            step();
            chk($sformatf("bp out_valid c%0d", c), out_valid, 1);
            chk($sformatf("bp src_a c%0d", c), src_a, 32'h40);
            chk($sformatf("bp fwd_hit c%0d", c), fwd_hit, 0);
        end
        sel_a = 2'd0;
        pc = 32'h80;
        out_ready = 1'b1;
        #1;
        chk("bp release in_ready", in_ready, 1);
        step();
        chk("bp release out_valid", out_valid, 1);
        chk("bp release src_a", src_a, 32'h80);

        pc = 32'h100;
        step();
        chk("mid accept src_a", src_a, 32'h100);
        out_ready = 1'b0;
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst out_valid", out_valid, 0);
        chk("async rst src_a", src_a, 0);
        chk("async rst stall_cnt", stall_cnt, 0);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        chk("post rst out_valid", out_valid, 0);

        load_hazard(1'b1);
        for (int c = 0; c < 6; c++) step();
        chk("sat wide stall_cnt", stall_cnt, 6);
        chk("sat narrow stall_cnt", stall_cnt_s, 3);
        chk("sat narrow hazard", hazard_s, 1);
        in_valid = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/srca_fwd_stage.md
# srca_fwd_stage

Parametrised, registered ALU operand-A stage for the pipelined core. It selects PC, rs1 register data or zero, and forwards rs1 from up to NFWD younger pipeline results. It stalls on a pending (not-yet-available) producer and registers the chosen operand into the EX boundary with a valid/ready handshake and flush. It sits between decode/register-read and the ALU, replacing the single-cycle 2:1 operand-A select.

## Interface
- XLEN, 32, datapath width
- NFWD, 2, number of forwarding sources; index 0 is the youngest and has the highest priority
- CNTW, 16, width of the saturating stall counter
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage accepts the instruction this cycle
- sel_a  in  2  operand mode: 0 = pc, 1 = rs1, 2 = zero, 3 = reserved (treated as zero)
- rs1_addr  in  5  source register index
- rdata1  in  XLEN  register-file read data
- pc  in  XLEN  instruction address
- fwd_valid  in  NFWD  forwarding slot holds a register-writing instruction
- fwd_pending  in  NFWD  the slot's result is not yet available (load in flight)
- fwd_rd  in  5*NFWD  destination index per slot, slot i at [5i+4:5i]
- fwd_data  in  XLEN*NFWD  result per slot, slot i at [XLEN*i+XLEN-1:XLEN*i]
- flush  in  1  kill the held and incoming instruction
- out_valid  out  1  src_a valid toward EX
- out_ready  in  1  EX consumes this cycle
- src_a  out  XLEN  registered operand A
- fwd_hit  out  1  registered: src_a came from a forwarding slot
- hazard  out  1  combinational: a pending producer is blocking acceptance
- stall_cnt  out  CNTW  saturating count of hazard cycles

## Operation
- needs_rs1 = in_valid & (sel_a == 1) & (rs1_addr != 0).
- Match i = fwd_valid[i] & (fwd_rd[i] == rs1_addr). The winner is the lowest-index match.
- hazard = needs_rs1 & winner exists & fwd_pending[winner]. A pending older slot shadowed by a non-pending younger match does not cause a hazard.
- Operand value:
  - pc for mode 0.
  - zero for modes 2 and 3.
  - For mode 1: zero when rs1_addr == 0, even if a slot claims rd 0; otherwise fwd_data[winner] if a winner exists; otherwise rdata1.
- in_ready = (~out_valid | out_ready) & ~hazard & ~flush.
- Accept when in_valid & in_ready:
  - out_valid <= 1.
  - src_a <= the operand value.
  - fwd_hit <= (mode 1 & winner exists & rs1_addr != 0).
- If out_ready & out_valid and there is no accept, out_valid <= 0. src_a and fwd_hit hold their last values.
- Held output is stable: while out_valid & ~out_ready, src_a and fwd_hit do not change regardless of the inputs.
- flush has priority over everything:
  - out_valid <= 0 next cycle.
  - in_ready = 0.
  - No accept.
  - stall_cnt does not increment that cycle.
- stall_cnt increments by 1 on each cycle with hazard & ~flush. It saturates at 2^CNTW-1 and never wraps.

## Timing
- Reset values: out_valid = 0, src_a = 0, fwd_hit = 0, stall_cnt = 0. Reset applies immediately on rst_n falling, independent of clk.
- A reset during a held (out_valid & ~out_ready) transfer discards the transfer.
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 per cycle when out_ready stays high.
- in_ready, hazard: combinational from the inputs and out_valid. There is no combinational path from in_valid to out_valid.
- Upstream must keep in_valid and its payload stable while in_ready = 0 (hazard or backpressure).
- The hazard clears the cycle fwd_pending[winner] drops. The instruction is accepted that same edge, using the now-valid fwd_data.

## Test plan
- Reset mid-transfer: accept pc = 0x100 with sel_a = 0, hold out_ready = 0, pulse rst_n low asynchronously -> out_valid = 0, src_a = 0, stall_cnt = 0 immediately.
- Priority forwarding: sel_a = 1, rs1 = 5, rdata1 = 0x11, slot0 = {rd 5, 0xAA}, slot1 = {rd 5, 0xBB} -> src_a = 0xAA, fwd_hit = 1 one cycle later.
- x0 guard: rs1 = 0, slot0 = {rd 0, 0xFF, pending 1} -> no hazard, src_a = 0, fwd_hit = 0.
- Load-use stall:
  - Setup: rs1 = 7, slot0 = {rd 7, pending 1} for 3 cycles, then pending 0 with data 0x1234.
  - Required: hazard = 1 for 3 cycles, stall_cnt = 3, then accept with src_a = 0x1234.
- Backpressure hold: accept 0x40, out_ready = 0 for 4 cycles while the inputs change -> src_a stays 0x40 and in_ready = 0; out_ready = 1 -> next instruction accepted the same edge.
- Flush and saturation:
  - Flush during a hazard -> out_valid = 0 and stall_cnt unchanged.
  - With CNTW = 2, hold the hazard for 6 cycles -> stall_cnt = 3.
